// File: rtl/mod_mul_serial_if.sv
// mod_mul_serial_if -- operand/result handshake bundle for mod_mul_serial.
//
// Signals:
//   i_in_valid  (master->slave)  operand pair on i_x/i_y is valid
//   o_in_ready  (slave->master)  block can accept an operand pair
//   i_x, i_y    (master->slave)  255-bit multiplicand / multiplier
//   o_out_valid (slave->master)  o_result holds a finished product
//   i_out_ready (master->slave)  downstream accepts o_result
//   o_result    (slave->master)  (x*y) mod (2^255-19)
//   o_busy      (slave->master)  block is not idle
interface mod_mul_serial_if;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [254:0] i_x;
    logic [254:0] i_y;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [254:0] o_result;
    logic         o_busy;

    modport slave (
        input  i_in_valid, i_x, i_y, i_out_ready,
        output o_in_ready, o_out_valid, o_result, o_busy
    );

    modport master (
        output i_in_valid, i_x, i_y, i_out_ready,
        input  o_in_ready, o_out_valid, o_result, o_busy
    );
endinterface

// File: rtl/mod_mul_serial.sv
// mod_mul_serial -- serial modular multiplier, result = (x*y) mod q,
// q = 2^255 - 19. Interleaved MSB-first double-and-add over the reduced
// multiplier, one conditional subtract of q per doubling/addition.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      mod_mul_serial_if.slave (valid/ready in, valid/ready out, busy)
//
// Latency: result valid at edge k+256 after acceptance at edge k.
// Optional macro MOD_MUL_RADIX4_EN: two multiplier bits per cycle using a
// precomputed {0, x, 2x, 3x} table; 2-cycle LOAD, result at edge k+130.
module mod_mul_serial (
    input logic          i_clk,
    input logic          i_rst_n,
    mod_mul_serial_if.slave bus
);

    localparam logic [255:0] Q = (256'd1 << 255) - 256'd19;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t       state, state_nxt;
    logic [254:0] xr;       // raw x after capture, reduced x after LOAD
    logic [254:0] yr;       // raw y captured on acceptance
    logic [255:0] y_sh;     // multiplier, consumed from the MSB end
    logic [254:0] acc;
    logic [254:0] acc_nxt;
    logic [7:0]   cnt;

`ifdef MOD_MUL_RADIX4_EN
    localparam logic [7:0] CNT_START = 8'd127;
    logic [254:0] x2, x3;
    logic         ld_ph;    // second LOAD cycle builds the 2x/3x table
`else
    localparam logic [7:0] CNT_START = 8'd254;
`endif

    // Single conditional subtract; caller guarantees t < 2q.
    function automatic logic [254:0] red(input logic [255:0] t);
        return (t >= Q) ? 255'(t - Q) : t[254:0];
    endfunction

    function automatic logic [254:0] mdbl(input logic [254:0] a);
        return red({a, 1'b0});
    endfunction

    function automatic logic [254:0] madd(input logic [254:0] a, input logic [254:0] b);
        return red({1'b0, a} + {1'b0, b});
    endfunction

    // One RUN step of the accumulator.
`ifdef MOD_MUL_RADIX4_EN
    logic [254:0] acc_dbl, addend;
    always_comb begin
        acc_dbl = mdbl(mdbl(acc));
        unique case (y_sh[255:254])
            2'd0:    addend = '0;
            2'd1:    addend = xr;
            2'd2:    addend = x2;
            default: addend = x3;
        endcase
        acc_nxt = madd(acc_dbl, addend);
    end
`else
    logic [254:0] acc_dbl;
    always_comb begin
        acc_dbl = mdbl(acc);
        acc_nxt = y_sh[255] ? madd(acc_dbl, xr) : acc_dbl;
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.i_in_valid) state_nxt = LOAD;
`ifdef MOD_MUL_RADIX4_EN
            LOAD: if (ld_ph) state_nxt = RUN;
`else
            LOAD: state_nxt = RUN;
`endif
            RUN:  if (cnt == 8'd0) state_nxt = DONE;
            DONE: if (bus.i_out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            xr   <= '0;
            yr   <= '0;
            y_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
`ifdef MOD_MUL_RADIX4_EN
            x2    <= '0;
            x3    <= '0;
            ld_ph <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: if (bus.i_in_valid) begin
                    xr  <= bus.i_x;
                    yr  <= bus.i_y;
                    acc <= '0;
`ifdef MOD_MUL_RADIX4_EN
                    ld_ph <= 1'b0;
`endif
                end
                LOAD: begin
`ifdef MOD_MUL_RADIX4_EN
                    if (!ld_ph) begin
                        xr    <= red({1'b0, xr});
                        y_sh  <= {1'b0, red({1'b0, yr})};
                        ld_ph <= 1'b1;
                    end else begin
                        x2  <= mdbl(xr);
                        x3  <= madd(mdbl(xr), xr);
                        cnt <= CNT_START;
                    end
`else
                    xr   <= red({1'b0, xr});
                    // Low bit is padding so yr[254] lands on y_sh[255].
                    y_sh <= {red({1'b0, yr}), 1'b0};
                    cnt  <= CNT_START;
`endif
                end
                RUN: begin
                    acc <= acc_nxt;
`ifdef MOD_MUL_RADIX4_EN
                    y_sh <= y_sh << 2;
`else
                    y_sh <= y_sh << 1;
`endif
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_in_ready  = (state == IDLE);
    assign bus.o_busy      = (state != IDLE);
    assign bus.o_out_valid = (state == DONE);
    assign bus.o_result    = acc;

endmodule

// File: tb/tb_mod_mul_serial.sv
// tb_mod_mul_serial -- randomized bench for mod_mul_serial with a
// behavioural (x*y) mod q reference and a per-cycle output compare.
module tb_mod_mul_serial;

    localparam logic [255:0] Q   = (256'd1 << 255) - 256'd19;
    localparam logic [254:0] Q15 = Q[254:0];
`ifdef MOD_MUL_RADIX4_EN
    localparam int LAT  = 130;
    localparam int LOADC = 2;
`else
    localparam int LAT  = 256;
    localparam int LOADC = 1;
`endif
    localparam int NRAND  = 200;
    localparam int MAXCYC = 90000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mod_mul_serial_if bus();

    mod_mul_serial dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [254:0] ref_mod(input logic [254:0] a, input logic [254:0] b);
        logic [511:0] p;
        p = {257'd0, a} * {257'd0, b};
        p = p % {256'd0, Q};
        return p[254:0];
    endfunction

    // Model state: one outstanding operation at most.
    int           cyc = 0;
    int           acc_cyc = 0;
    int           n_done = 0;
    logic         pending = 1'b0;
    logic [254:0] exp_res = '0;

    always @(posedge clk) begin
        logic ov_now;
        ov_now = pending && (cyc >= acc_cyc + LAT);
        cyc = cyc + 1;
        if (!rst_n) pending = 1'b0;
        else if (ov_now && bus.i_out_ready) begin
            pending = 1'b0;
            n_done++;
        end else if (!pending && bus.i_in_valid) begin
            pending = 1'b1;
            acc_cyc = cyc;
            exp_res = ref_mod(bus.i_x, bus.i_y);
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", {255'd0, bus.o_busy}, 256'd0);
            chk("rst_out_valid", {255'd0, bus.o_out_valid}, 256'd0);
            chk("rst_result", {1'b0, bus.o_result}, 256'd0);
        end else begin
            logic exp_ov;
            exp_ov = pending && (cyc >= acc_cyc + LAT);
            chk("in_ready", {255'd0, bus.o_in_ready}, {255'd0, !pending});
            chk("busy", {255'd0, bus.o_busy}, {255'd0, pending});
            chk("out_valid", {255'd0, bus.o_out_valid}, {255'd0, exp_ov});
            if (exp_ov) chk("result", {1'b0, bus.o_result}, {1'b0, exp_res});
        end
    end

    function automatic logic [254:0] rand_op();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        case ($urandom_range(0, 9))
            0: r = 256'd0;
            1: r = Q - 256'd1;
            2: r = Q + 256'($urandom_range(0, 18));
            3: r = {1'b0, {255{1'b1}}};
            default: ;
        endcase
        return r[254:0];
    endfunction

    task automatic do_op(input logic [254:0] x, input logic [254:0] y,
                         input logic [254:0] lit, input int hold, input string nm);
        int n;
        @(negedge clk);
        bus.i_x = x;
        bus.i_y = y;
        bus.i_in_valid = 1'b1;
        bus.i_out_ready = (hold == 0);
        @(negedge clk);
        bus.i_in_valid = 1'b0;
        n = 0;
        while (!bus.o_out_valid && n < LAT + 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_out_valid) chk({nm, "_timeout"}, 256'd0, 256'd1);
        else chk(nm, {1'b0, bus.o_result}, {1'b0, lit});
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk({nm, "_held"}, {1'b0, bus.o_result}, {1'b0, lit});
            chk({nm, "_held_ready"}, {255'd0, bus.o_in_ready}, 256'd0);
            bus.i_out_ready = 1'b1;
        end
        @(negedge clk);
        chk({nm, "_ready_after"}, {255'd0, bus.o_in_ready}, 256'd1);
    endtask

    initial begin
        logic [254:0] p254, ones;
        int guard, target;
        p254 = 255'd1 << 254;
        ones = {255{1'b1}};
        bus.i_in_valid  = 1'b0;
        bus.i_x         = '0;
        bus.i_y         = '0;
        bus.i_out_ready = 1'b1;

        // Pin the reference model with hand-computed values.
        chk("ref_1x1", {1'b0, ref_mod(255'd1, 255'd1)}, 256'd1);
        chk("ref_qm1_sq", {1'b0, ref_mod(Q15 - 255'd1, Q15 - 255'd1)}, 256'd1);
        chk("ref_2p254x2", {1'b0, ref_mod(p254, 255'd2)}, 256'd19);
        chk("ref_qp5", {1'b0, ref_mod(Q15 + 255'd5, 255'd1)}, 256'd5);
        chk("ref_3x7", {1'b0, ref_mod(255'd3, 255'd7)}, 256'd21);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(255'd1, 255'd1, 255'd1, 0, "one_by_one");
        do_op(Q15 - 255'd1, Q15 - 255'd1, 255'd1, 0, "qm1_sq");
        do_op(p254, 255'd2, 255'd19, 0, "p254_x2");
        do_op(Q15 + 255'd5, 255'd1, 255'd5, 0, "unreduced");
        do_op(255'd0, ones, 255'd0, 0, "zero_x");
        do_op(255'd12345, 255'd678, 255'd8369910, 10, "backpressure");

        // Abort a run mid-way with an asynchronous reset pulse.
        @(negedge clk);
        bus.i_x = 255'd5;
        bus.i_y = Q15 - 255'd2;
        bus.i_in_valid = 1'b1;
        @(negedge clk);
        bus.i_in_valid = 1'b0;
        repeat (LOADC + 99) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {255'd0, bus.o_busy}, 256'd0);
        chk("abort_out_valid", {255'd0, bus.o_out_valid}, 256'd0);
        chk("abort_result", {1'b0, bus.o_result}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(255'd3, 255'd7, 255'd21, 0, "after_abort");

        // Random operands, random valid and backpressure.
        target = n_done + NRAND;
        guard = 0;
        while (n_done < target && guard < MAXCYC) begin
            @(negedge clk);
            bus.i_in_valid  = ($urandom_range(0, 3) != 0);
            bus.i_x         = rand_op();
            bus.i_y         = rand_op();
            bus.i_out_ready = ($urandom_range(0, 2) != 0);
            guard++;
        end
        if (n_done < target) chk("random_timeout", 256'(n_done), 256'(target));
        bus.i_in_valid  = 1'b0;
        bus.i_out_ready = 1'b1;
        repeat (LAT + 5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
